gcd_engine: RTL and testbench
=============================

Name: gcd_engine

Overview:
Parametrised GCD unit: iterative subtractive Euclid controller plus operand datapath in one block. Replaces the fixed, free-running controller/datapath pair with a WIDTH-generic engine. Adds valid/ready handshakes on input and output, zero-operand handling, reset, and result back-pressure. Sits between an operand producer and a result consumer in the arithmetic subsystem.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a_in/b_in are presented.
- in_ready  out  1  engine can accept operands; high only in IDLE.
- a_in  in  WIDTH  operand A, unsigned.
- b_in  in  WIDTH  operand B, unsigned.
- out_valid  out  1  gcd_out is valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- gcd_out  out  WIDTH  result, unsigned.
- busy  out  1  high in CALC and DONE.
- cycles_out  out  WIDTH  compute-cycle count; present only with GCD_CYCLE_COUNT_EN.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; A, B and result registers cleared to 0; in_ready=1, out_valid=0, busy=0, gcd_out=0.
- Reset has priority over every other condition in every state. Reset mid-computation discards the operation; no result is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. If in_valid=1 at an edge: capture A<=a_in, B<=b_in, go to CALC. Otherwise stay in IDLE.
- CALC: one decision per cycle, evaluated on the registered A and B, in this priority order:
  1. A==0: result<=B, go to DONE.
  2. B==0: result<=A, go to DONE.
  3. A==B: result<=A, go to DONE.
  4. A>B: A<=A-B, stay in CALC.
  5. A<B: B<=B-A, stay in CALC.
- Subtraction is WIDTH-bit unsigned and never underflows, because the larger operand is always the minuend.
- in_valid is ignored outside IDLE.
- DONE: out_valid=1; gcd_out=result, held stable until handshake. If out_ready=1 at an edge, go to IDLE. in_ready stays 0 in DONE, so the next operand pair is accepted no earlier than the cycle after the result handshake.
- Latency: if N subtractions are needed, out_valid is high starting (N+1) edges after the accept edge.
  - Zero or equal operands: N=0, so latency is 1.
  - Worst case is (1, 2^WIDTH-1): N=2^WIDTH-2, so latency is 2^WIDTH-1.
- Boundary results:
  - gcd(0,0)=0.
  - gcd(0,x)=x and gcd(x,0)=x.
  - Worst-case operands never loop indefinitely.
- Outputs are registered or decoded from state only; there is no combinational path from in_valid or out_ready to any output.

Optional Feature:
- GCD_CYCLE_COUNT_EN.
- When defined:
  - cycles_out port exists.
  - A WIDTH-bit counter clears on the accept edge and increments on each edge spent in CALC, including the final CALC edge.
  - Value is frozen in DONE, and equals latency for the operation.
  - Cleared by rst.
  - Cannot overflow, since the maximum is 2^WIDTH-1.
- When undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package gcd_pkg contains:
  - state typedef: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - Default-width constant.
- Sub-module gcd_datapath contains:
  - A, B and result registers.
  - Subtractor.
  - Comparator producing lt/gt/eq/a_zero/b_zero flags.
  - Controlled by load/subA/subB/latch strobes.
- gcd_engine holds the FSM and the handshake logic.

Test Plan:
- WIDTH=8, (12,8) accepted at edge 0 -> out_valid after edge 3, gcd_out=4; with GCD_CYCLE_COUNT_EN, cycles_out=3.
- (0,9) -> gcd_out=9 after 1 edge; (9,0) -> 9; (0,0) -> 0; (7,7) -> 7 after 1 edge.
- (1,255) -> gcd_out=1 after 255 edges; (255,1) -> same; no hang, no underflow.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and gcd_out stay stable, in_ready=0. Raise out_ready -> IDLE next edge; a new operand pair is accepted the following edge.
- rst=1 pulsed during CALC of (200,3) -> next cycle IDLE, in_ready=1, out_valid=0. Subsequent (48,18) -> 6.
- Random regression, WIDTH=4 and WIDTH=16: compare against a reference GCD model, with random in_valid/out_ready gaps.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive-Euclid GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/gcd_engine_if.sv
// Operand/result handshake bundle for gcd_engine.
// cycles_out exists only when GCD_CYCLE_COUNT_EN is defined.
interface gcd_engine_if
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] gcd_out;
  logic             busy;
`ifdef GCD_CYCLE_COUNT_EN
  logic [WIDTH-1:0] cycles_out;
`endif

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, gcd_out, busy
`ifdef GCD_CYCLE_COUNT_EN
    , input cycles_out
`endif
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, gcd_out, busy
`ifdef GCD_CYCLE_COUNT_EN
    , output cycles_out
`endif
  );
endinterface

// File: rtl/gcd_datapath.sv
// Operand and result registers, subtractor and comparator for gcd_engine.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             sub_a,
  input  logic             sub_b,
  input  logic             latch,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             a_zero,
  output logic             b_zero,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  assign a_zero = (a_q == '0);
  assign b_zero = (b_q == '0);
  assign eq     = (a_q == b_q);
  assign gt     = (a_q >  b_q);
  assign lt     = (a_q <  b_q);

  // The controller only asserts sub_a when A>B and sub_b when A<B, so the
  // minuend is always the larger operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
    end else begin
      if (load) begin
        a_q <= a_in;
        b_q <= b_in;
      end else begin
        if (sub_a) a_q <= a_q - b_q;
        if (sub_b) b_q <= b_q - a_q;
      end
      if (latch) result <= a_zero ? b_q : a_q;
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Iterative subtractive-Euclid GCD engine with valid/ready handshakes.
// Optional compute-cycle counter enabled by defining GCD_CYCLE_COUNT_EN.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  gcd_engine_if.slave  bus
);

  gcd_state_t       state;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             a_zero, b_zero, eq, gt, lt;
  logic             load, sub_a, sub_b, latch, finish;
  logic [WIDTH-1:0] result;

  assign load   = (state == IDLE) && bus.in_valid;
  assign finish = (state == CALC) && (a_zero || b_zero || eq);
  assign latch  = finish;
  assign sub_a  = (state == CALC) && !finish && gt;
  assign sub_b  = (state == CALC) && !finish && lt;

  gcd_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .sub_a  (sub_a),
    .sub_b  (sub_b),
    .latch  (latch),
    .a_in   (bus.a_in),
    .b_in   (bus.b_in),
    .a_zero (a_zero),
    .b_zero (b_zero),
    .eq     (eq),
    .gt     (gt),
    .lt     (lt),
    .result (result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          state      <= CALC;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
        end
        CALC: if (finish) begin
          state       <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: if (bus.out_ready) begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.gcd_out   = result;

`ifdef GCD_CYCLE_COUNT_EN
  // Counts every edge spent in CALC, so the frozen value equals the latency.
  logic [WIDTH-1:0] cyc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else if (load) begin
      cyc_q <= '0;
    end else if (state == CALC) begin
      cyc_q <= cyc_q + WIDTH'(1);
    end
  end

  assign bus.cycles_out = cyc_q;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Directed and random bench for gcd_engine (WIDTH=8 main instance, WIDTH=4 regression instance).
module tb_gcd_engine;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  gcd_engine_if #(.WIDTH(8)) bus8 ();
  gcd_engine_if #(.WIDTH(4)) bus4 ();

  gcd_engine #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus8));
  gcd_engine #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    int         lat;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_gcd(input int a, input int b);
    int x = a, y = b, t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Accept (a,b) on the next edge and wait for the result; leaves the engine in DONE.
  task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] g, input int lat);
    int k;
    check({nm, "_in_ready"}, bus8.in_ready, 1);
    bus8.a_in     = a;
    bus8.b_in     = b;
    bus8.in_valid = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    k = 0;
    while (!bus8.out_valid && k < 400) begin
      step();
      k++;
    end
    check({nm, "_out_valid"}, bus8.out_valid, 1);
    check({nm, "_gcd"}, bus8.gcd_out, g);
    check({nm, "_latency"}, k, lat);
`ifdef GCD_CYCLE_COUNT_EN
    check({nm, "_cycles"}, bus8.cycles_out, lat);
`endif
  endtask

  task automatic release_result(input string nm);
    bus8.out_ready = 1'b1;
    step();
    bus8.out_ready = 1'b0;
    check({nm, "_back_idle"}, {bus8.in_ready, bus8.out_valid, bus8.busy}, 3'b100);
  endtask

  task automatic rand8(input int n);
    int k;
    bit done;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) step();
      bus8.a_in     = 8'($urandom_range(0, 255));
      bus8.b_in     = 8'($urandom_range(0, 255));
      bus8.in_valid = 1'b1;
      step();
      bus8.in_valid = 1'b0;
      done = 0;
      k    = 0;
      while (!done && k < 600) begin
        bus8.out_ready = 1'($urandom_range(0, 1));
        if (bus8.out_valid && bus8.out_ready) begin
          check($sformatf("rand8_%0d_gcd(%0d,%0d)", i, bus8.a_in, bus8.b_in),
                bus8.gcd_out, ref_gcd(int'(bus8.a_in), int'(bus8.b_in)));
          done = 1;
        end
        step();
        k++;
      end
      bus8.out_ready = 1'b0;
      if (!done) check($sformatf("rand8_%0d_timeout", i), 0, 1);
    end
  endtask

  task automatic rand4(input int n);
    int k;
    bit done;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) step();
      bus4.a_in     = 4'($urandom_range(0, 15));
      bus4.b_in     = 4'($urandom_range(0, 15));
      bus4.in_valid = 1'b1;
      step();
      bus4.in_valid = 1'b0;
      done = 0;
      k    = 0;
      while (!done && k < 60) begin
        bus4.out_ready = 1'($urandom_range(0, 1));
        if (bus4.out_valid && bus4.out_ready) begin
          check($sformatf("rand4_%0d_gcd(%0d,%0d)", i, bus4.a_in, bus4.b_in),
                bus4.gcd_out, ref_gcd(int'(bus4.a_in), int'(bus4.b_in)));
          done = 1;
        end
        step();
        k++;
      end
      bus4.out_ready = 1'b0;
      if (!done) check($sformatf("rand4_%0d_timeout", i), 0, 1);
    end
  endtask

  initial begin
    vecs[0]  = '{a: 8'd12,  b: 8'd8,   g: 8'd4,  lat: 3};
    vecs[1]  = '{a: 8'd0,   b: 8'd9,   g: 8'd9,  lat: 1};
    vecs[2]  = '{a: 8'd9,   b: 8'd0,   g: 8'd9,  lat: 1};
    vecs[3]  = '{a: 8'd0,   b: 8'd0,   g: 8'd0,  lat: 1};
    vecs[4]  = '{a: 8'd7,   b: 8'd7,   g: 8'd7,  lat: 1};
    vecs[5]  = '{a: 8'd1,   b: 8'd255, g: 8'd1,  lat: 255};
    vecs[6]  = '{a: 8'd255, b: 8'd1,   g: 8'd1,  lat: 255};
    vecs[7]  = '{a: 8'd48,  b: 8'd18,  g: 8'd6,  lat: 5};
    vecs[8]  = '{a: 8'd17,  b: 8'd5,   g: 8'd1,  lat: 7};
    vecs[9]  = '{a: 8'd100, b: 8'd75,  g: 8'd25, lat: 4};
    vecs[10] = '{a: 8'd128, b: 8'd64,  g: 8'd64, lat: 2};

    rst = 1'b1;
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.a_in = '0; bus8.b_in = '0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.a_in = '0; bus4.b_in = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_ctrl", {bus8.in_ready, bus8.out_valid, bus8.busy}, 3'b100);
    check("reset_gcd", bus8.gcd_out, 0);
`ifdef GCD_CYCLE_COUNT_EN
    check("reset_cycles", bus8.cycles_out, 0);
`endif

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].lat);
      release_result($sformatf("vec%0d", i));
    end

    // Back-pressure: result held in DONE, stray in_valid ignored.
    run_op("bp", 8'd12, 8'd8, 8'd4, 3);
    bus8.in_valid = 1'b1;
    bus8.a_in     = 8'd99;
    bus8.b_in     = 8'd33;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp_hold%0d", i),
            {bus8.out_valid, bus8.in_ready, bus8.busy, bus8.gcd_out}, {3'b101, 8'd4});
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    step();
    bus8.out_ready = 1'b0;
    check("bp_idle", {bus8.in_ready, bus8.out_valid}, 2'b10);
    bus8.a_in     = 8'd7;
    bus8.b_in     = 8'd7;
    bus8.in_valid = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    check("bp_accept", {bus8.in_ready, bus8.busy}, 2'b01);
    step();
    check("bp_next_gcd", {bus8.out_valid, bus8.gcd_out}, {1'b1, 8'd7});
    release_result("bp_next");

    // Reset mid-computation discards the operation.
    bus8.a_in     = 8'd200;
    bus8.b_in     = 8'd3;
    bus8.in_valid = 1'b1;
    step();
    bus8.in_valid = 1'b0;
    repeat (10) step();
    check("rst_mid_busy", bus8.busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_ctrl", {bus8.in_ready, bus8.out_valid, bus8.busy}, 3'b100);
    check("rst_mid_gcd", bus8.gcd_out, 0);
    step();
    check("rst_mid_no_result", bus8.out_valid, 0);
    run_op("after_rst", 8'd48, 8'd18, 8'd6, 5);
    release_result("after_rst");

    rand8(40);
    rand4(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
